pkt_tx_buffer: RTL and testbench
================================

Name: pkt_tx_buffer

Overview:
Single-clock successor to the packet output buffer that sits between the packet processor and the serial/USB byte sender.
- Accepts packet words of LANES bytes into a circular RAM. Words are held uncommitted until wr_commit, discarded on wr_abort, and drop a whole packet on overflow instead of leaving a partial one.
- Inserts a two-word sync frame on sync acquisition and every SYNC_INTERVAL packets.
- Serialises committed words LSB-byte-first over a valid/ready byte interface, and reports fill level.

Parameters:
LANES, 2, bytes per packet word (1..4); word width W = 8*LANES.
DEPTH_LOG2, 10, log2 of RAM depth in words; usable capacity 2^DEPTH_LOG2 - 1.
SYNC_INTERVAL, 2048, committed packets between forced sync frames (>=1).
OVF_STRETCH_LOG2, 17, overflow indicator stretch length is 2^OVF_STRETCH_LOG2 - 1 cycles.

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
sync  in  1  upstream decoder in-sync flag
wr_valid  in  1  wr_data holds a packet word this cycle
wr_data  in  W  packet word; byte 0 = [7:0]
wr_abort  in  1  discard the open (uncommitted) packet
wr_commit  in  1  close the open packet and make it readable
data_out  out  8  output byte
data_valid  out  1  data_out is valid
data_ready  in  1  consumer accepts data_out this cycle
overflow  out  1  stretched overflow/drop indicator
fill  out  DEPTH_LOG2  committed words not yet fully read (wp - rp, modulo depth)

Behaviour:
Reset:
- rp, wp, wp_open = 0; lane = 0; data_valid = 0; data_out = 0; overflow = 0; fill = 0.
- pkt_bad = 0; sync_pend = 1, so the stream always starts with a sync frame.
- Reset mid-packet or mid-byte discards everything.

Pointers:
- wp = committed write pointer; wp_open = write pointer of the open packet; rp = read pointer.
- All pointers are DEPTH_LOG2 bits and wrap naturally.
- Full when wp_open + 1 == rp.

Write priority per cycle: wr_abort > wr_commit > wr_valid.
- wr_abort: wp_open <= wp; pkt_bad <= 0. Any wr_valid word in the same cycle is ignored.
- wr_valid without abort:
  - If not full and pkt_bad = 0: mem[wp_open] <= wr_data; wp_open++.
  - Otherwise set pkt_bad; the word is dropped.
- wr_commit:
  - A wr_valid word in the same cycle is stored first (subject to the full check) and included in the packet.
  - If the packet is good: wp <= the new wp_open.
  - If pkt_bad: wp_open <= wp, pkt_bad <= 0, and the packet is dropped entirely.
  - A commit with no words is legal and leaves wp unchanged.
  - Each commit of a good, non-empty packet increments pkt_cnt. When pkt_cnt reaches SYNC_INTERVAL-1 it wraps to 0 and sets sync_pend.
- Overflow indicator: the first word lost to a full buffer in a packet reloads the stretch counter to all-ones; overflow = (counter != 0), decremented every cycle.

Sync state machine: states IDLE, SYNC_A, SYNC_B.
- sync rising edge (registered sync_q) sets sync_pend.
- IDLE -> SYNC_A when all of:
  - sync_pend = 1
  - no open packet (wp_open == wp, pkt_bad = 0)
  - wr_valid = 0, wr_commit = 0, wr_abort = 0
  - at least 2 free slots
- SYNC_A: writes all-ones; advances wp and wp_open together; -> SYNC_B.
- SYNC_B: writes all-ones with bit W-1 cleared; advances both pointers; clears sync_pend; -> IDLE.
- Sync words are committed immediately. wr_valid arriving during SYNC_A/B is dropped and sets pkt_bad; upstream must hold off while sync_busy is internally high (one packet lost otherwise, acceptable).
- A sync rising edge during an open packet is deferred until after that packet's commit or abort.

Read side:
- Output register loads when (data_valid == 0 or data_ready == 1).
  - If rp != wp: data_out <= mem[rp][8*lane +: 8]; data_valid <= 1; lane++. When lane == LANES-1: lane <= 0 and rp++.
  - If rp == wp: data_valid <= 0.
- data_out must hold stable while data_valid && !data_ready.
- Latency: wr_commit sampled at edge E → data_valid high after edge E+1 when the output stage is empty.
- Full throughput is one byte per cycle with data_ready held high.
- fill is computed combinationally from the registered wp and rp.

Optional Feature:
Macro PKT_TX_DROP_COUNT_EN.
- Defined: adds output port drop_count [15:0]. It increments (saturating at 16'hFFFF) on every commit of a pkt_bad packet and on every commit with a word dropped in the sync states, and resets to 0.
- Undefined: the port and counter are absent; drop behaviour is otherwise identical.

Test Plan:
1. After reset, sync 0→1, then packet {16'h1234, 16'h5678} committed (LANES=2), data_ready=1 → bytes FF,FF,FF,7F,34,12,78,56, then data_valid=0.
2. 3-word packet followed by wr_abort, then a 1-word packet 16'hBEEF committed → only 0xEF,0xBE emitted after the sync frame; fill peaks at 1.
3. DEPTH_LOG2=4, data_ready=0, commit 14 words, then write 3-word packet and commit → packet dropped; fill stays 14; overflow high for 2^OVF_STRETCH_LOG2-1 cycles; drop_count=1 when enabled.
4. SYNC_INTERVAL=4, five 1-word packets with sync held high → a sync frame (FF,FF,FF,7F) appears before packet 5 only.
5. data_ready toggling 1,0,0,1 during a word → data_out holds its value through stalls; no byte duplicated or skipped; rp wraps from 2^DEPTH_LOG2-1 to 0 correctly.
6. wr_valid + wr_commit in the same cycle with 16'hA5C3 → word included, bytes C3,A5 emitted; wr_abort + wr_commit in the same cycle → nothing committed.

Source files
------------

// File: rtl/pkt_tx_buffer.sv
// Packet transmit buffer: circular word RAM with commit/abort, periodic sync frames, byte serialiser.
// Define PKT_TX_DROP_COUNT_EN to add the drop_count_o counter port.
module pkt_tx_buffer #(
    parameter int LANES            = 2,
    parameter int DEPTH_LOG2       = 10,
    parameter int SYNC_INTERVAL    = 2048,
    parameter int OVF_STRETCH_LOG2 = 17
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  sync_i,
    input  logic                  wr_valid_i,
    input  logic [8*LANES-1:0]    wr_data_i,
    input  logic                  wr_abort_i,
    input  logic                  wr_commit_i,
    output logic [7:0]            data_out_o,
    output logic                  data_valid_o,
    input  logic                  data_ready_i,
    output logic                  overflow_o,
`ifdef PKT_TX_DROP_COUNT_EN
    output logic [15:0]           drop_count_o,
`endif
    output logic [DEPTH_LOG2-1:0] fill_o
);
    localparam int W     = 8 * LANES;
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int LW    = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int CW    = (SYNC_INTERVAL > 1) ? $clog2(SYNC_INTERVAL) : 1;

    typedef enum logic [1:0] {IDLE, SYNC_A, SYNC_B} state_t;

    logic [W-1:0]            mem_q [DEPTH];
    state_t                  state_q, state_d;
    logic [DEPTH_LOG2-1:0]   rp_q, wp_q, wp_d, wpo_q, wpo_d, wpo_n, wpo_inc, free;
    logic [LW-1:0]           lane_q;
    logic [7:0]              dout_q;
    logic                    dvalid_q;
    logic [OVF_STRETCH_LOG2-1:0] ovf_q;
    logic                    bad_q, bad_d, bad_n;
    logic                    pend_q, pend_d;
    logic                    sync_q;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic                    mem_we, ovf_load, full;
    logic [W-1:0]            mem_wd, rd_word;

    assign wpo_inc = wpo_q + 1'b1;
    assign full    = (wpo_inc == rp_q);
    assign free    = rp_q - wpo_q - 1'b1;
    assign rd_word = mem_q[rp_q];

    always_comb begin
        state_d  = state_q;
        wp_d     = wp_q;
        wpo_d    = wpo_q;
        wpo_n    = wpo_q;
        bad_d    = bad_q;
        bad_n    = bad_q;
        pend_d   = pend_q;
        cnt_d    = cnt_q;
        mem_we   = 1'b0;
        mem_wd   = wr_data_i;
        ovf_load = 1'b0;
        case (state_q)
            SYNC_A, SYNC_B: begin
                // Sync words are committed straight away; any upstream word now is lost.
                mem_we = 1'b1;
                mem_wd = (state_q == SYNC_A) ? {W{1'b1}} : {1'b0, {(W-1){1'b1}}};
                wp_d   = wp_q + 1'b1;
                wpo_d  = wpo_q + 1'b1;
                if (state_q == SYNC_B) begin
                    pend_d  = 1'b0;
                    state_d = IDLE;
                end else begin
                    state_d = SYNC_B;
                end
                if (wr_abort_i)       bad_d = 1'b0;
                else if (wr_commit_i) bad_d = 1'b0;
                else if (wr_valid_i)  bad_d = 1'b1;
            end
            default: begin
                if (wr_abort_i) begin
                    wpo_d = wp_q;
                    bad_d = 1'b0;
                end else begin
                    if (wr_valid_i) begin
                        if (!full && !bad_q) begin
                            mem_we = 1'b1;
                            wpo_n  = wpo_inc;
                        end else begin
                            bad_n    = 1'b1;
                            ovf_load = full && !bad_q;
                        end
                    end
                    if (wr_commit_i) begin
                        if (bad_n) begin
                            wpo_d = wp_q;
                            bad_d = 1'b0;
                        end else begin
                            wp_d  = wpo_n;
                            wpo_d = wpo_n;
                            if (wpo_n != wp_q) begin
                                if (cnt_q == CW'(SYNC_INTERVAL - 1)) begin
                                    cnt_d  = '0;
                                    pend_d = 1'b1;
                                end else begin
                                    cnt_d = cnt_q + 1'b1;
                                end
                            end
                        end
                    end else begin
                        wpo_d = wpo_n;
                        bad_d = bad_n;
                    end
                end
                if (pend_q && (wpo_q == wp_q) && !bad_q && !wr_valid_i && !wr_commit_i &&
                    !wr_abort_i && (free >= DEPTH_LOG2'(2)))
                    state_d = SYNC_A;
            end
        endcase
        if (sync_i && !sync_q) pend_d = 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (mem_we) mem_q[wpo_q] <= mem_wd;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            rp_q     <= '0;
            wp_q     <= '0;
            wpo_q    <= '0;
            lane_q   <= '0;
            dout_q   <= '0;
            dvalid_q <= 1'b0;
            ovf_q    <= '0;
            bad_q    <= 1'b0;
            pend_q   <= 1'b1;
            sync_q   <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q <= state_d;
            wp_q    <= wp_d;
            wpo_q   <= wpo_d;
            bad_q   <= bad_d;
            pend_q  <= pend_d;
            cnt_q   <= cnt_d;
            sync_q  <= sync_i;
            if (ovf_load)        ovf_q <= '1;
            else if (ovf_q != '0) ovf_q <= ovf_q - 1'b1;
            // Output stage refills whenever empty or being drained.
            if (!dvalid_q || data_ready_i) begin
                if (rp_q != wp_q) begin
                    dout_q   <= rd_word[8*lane_q +: 8];
                    dvalid_q <= 1'b1;
                    if (lane_q == LW'(LANES - 1)) begin
                        lane_q <= '0;
                        rp_q   <= rp_q + 1'b1;
                    end else begin
                        lane_q <= lane_q + 1'b1;
                    end
                end else begin
                    dvalid_q <= 1'b0;
                end
            end
        end
    end

`ifdef PKT_TX_DROP_COUNT_EN
    logic [15:0] drop_q;
    logic        drop_inc;
    assign drop_inc = !wr_abort_i && wr_commit_i &&
                      ((state_q != IDLE) ? (bad_q || wr_valid_i) : bad_n);
    always_ff @(posedge clk_i) begin
        if (rst_i)                            drop_q <= '0;
        else if (drop_inc && drop_q != 16'hFFFF) drop_q <= drop_q + 1'b1;
    end
    assign drop_count_o = drop_q;
`endif

    assign data_out_o   = dout_q;
    assign data_valid_o = dvalid_q;
    assign overflow_o   = (ovf_q != '0);
    assign fill_o       = wp_q - rp_q;
endmodule

// File: tb/tb_pkt_tx_buffer.sv
// Directed bench for pkt_tx_buffer (LANES=2, 16-word RAM, sync every 4 packets, 15-cycle overflow stretch).
module tb_pkt_tx_buffer;
    localparam int LANES = 2;
    localparam int DL    = 4;
    localparam int SI    = 4;
    localparam int OL    = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          sync, wr_valid, wr_abort, wr_commit, data_ready;
    logic [15:0]   wr_data;
    logic [7:0]    data_out;
    logic          data_valid, overflow;
    logic [DL-1:0] fill;
`ifdef PKT_TX_DROP_COUNT_EN
    logic [15:0]   drop_count;
`endif

    int            checks = 0;
    int            failures = 0;
    int            ovf_seen = 0;
    logic [DL-1:0] fill_max = '0;
    logic [7:0]    got_q[$];
    logic [7:0]    exp_q[$];

    always #5 clk = ~clk;

    pkt_tx_buffer #(.LANES(LANES), .DEPTH_LOG2(DL), .SYNC_INTERVAL(SI), .OVF_STRETCH_LOG2(OL)) dut (
        .clk_i(clk), .rst_i(rst), .sync_i(sync), .wr_valid_i(wr_valid), .wr_data_i(wr_data),
        .wr_abort_i(wr_abort), .wr_commit_i(wr_commit), .data_out_o(data_out),
        .data_valid_o(data_valid), .data_ready_i(data_ready), .overflow_o(overflow),
`ifdef PKT_TX_DROP_COUNT_EN
        .drop_count_o(drop_count),
`endif
        .fill_o(fill)
    );

    // Byte handshakes complete on the next rising edge; sample them midway.
    always @(negedge clk) begin
        if (!rst) begin
            if (data_valid && data_ready) got_q.push_back(data_out);
            if (overflow) ovf_seen++;
            if (fill > fill_max) fill_max = fill;
        end
    end

    task automatic step(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic put(input logic [15:0] d, input logic v, input logic c, input logic a);
        wr_data = d; wr_valid = v; wr_commit = c; wr_abort = a;
        step();
        wr_valid = 1'b0; wr_commit = 1'b0; wr_abort = 1'b0;
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while ((fill != '0 || data_valid) && n < 200) begin
            step();
            n++;
        end
        chk({tag, " drain_done"}, 32'(n < 200), 32'd1);
    endtask

    task automatic chk_stream(input string tag);
        chk({tag, " len"}, 32'(got_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++)
            if (i < got_q.size()) chk($sformatf("%s byte%0d", tag, i), 32'(got_q[i]), 32'(exp_q[i]));
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic push_sync();
        exp_q.push_back(8'hFF); exp_q.push_back(8'hFF);
        exp_q.push_back(8'hFF); exp_q.push_back(8'h7F);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step(2);
        rst = 1'b0;
        sync = 1'b1;
        step(6);
    endtask

    initial begin
        logic [15:0] w;
        sync = 1'b0; wr_valid = 1'b0; wr_abort = 1'b0; wr_commit = 1'b0;
        wr_data = '0; data_ready = 1'b1;

        // Reset state
        step(2);
        chk("rst data_valid", 32'(data_valid), 32'd0);
        chk("rst data_out", 32'(data_out), 32'd0);
        chk("rst overflow", 32'(overflow), 32'd0);
        chk("rst fill", 32'(fill), 32'd0);
`ifdef PKT_TX_DROP_COUNT_EN
        chk("rst drop_count", 32'(drop_count), 32'd0);
`endif
        rst = 1'b0;
        sync = 1'b1;
        step(6);

        // Sync frame then a two-word packet
        put(16'h1234, 1'b1, 1'b0, 1'b0);
        put(16'h5678, 1'b1, 1'b1, 1'b0);
        drain("t1");
        push_sync();
        exp_q.push_back(8'h34); exp_q.push_back(8'h12);
        exp_q.push_back(8'h78); exp_q.push_back(8'h56);
        chk_stream("t1");
        chk("t1 valid_end", 32'(data_valid), 32'd0);

        // Aborted packet leaves nothing behind
        fill_max = '0;
        put(16'hAAAA, 1'b1, 1'b0, 1'b0);
        put(16'hBBBB, 1'b1, 1'b0, 1'b0);
        put(16'hCCCC, 1'b1, 1'b0, 1'b0);
        chk("t2 fill_open", 32'(fill), 32'd0);
        put(16'h0000, 1'b0, 1'b0, 1'b1);
        put(16'hBEEF, 1'b1, 1'b1, 1'b0);
        drain("t2");
        exp_q.push_back(8'hEF); exp_q.push_back(8'hBE);
        chk_stream("t2");
        chk("t2 fill_peak", 32'(fill_max), 32'd1);

        // Same-cycle valid+commit, latency, abort+commit
        put(16'hA5C3, 1'b1, 1'b1, 1'b0);
        chk("t6 lat_edgeE", 32'(data_valid), 32'd0);
        step();
        chk("t6 lat_edgeE1", 32'(data_valid), 32'd1);
        chk("t6 first_byte", 32'(data_out), 32'hC3);
        drain("t6");
        exp_q.push_back(8'hC3); exp_q.push_back(8'hA5);
        chk_stream("t6");
        put(16'h1111, 1'b1, 1'b0, 1'b0);
        put(16'h2222, 1'b1, 1'b1, 1'b1);
        step(3);
        chk("t6 abort_commit_fill", 32'(fill), 32'd0);
        put(16'h0000, 1'b0, 1'b1, 1'b0);
        step(3);
        chk("t6 empty_commit_fill", 32'(fill), 32'd0);
        chk_stream("t6 nothing");

        // Forced sync frame after every fourth packet
        do_reset();
        for (int k = 1; k <= 5; k++) begin
            put({8'hC0 + 8'(k), 8'hD0 + 8'(k)}, 1'b1, 1'b1, 1'b0);
            step(4);
        end
        drain("t4");
        push_sync();
        for (int k = 1; k <= 4; k++) begin
            exp_q.push_back(8'hD0 + 8'(k)); exp_q.push_back(8'hC0 + 8'(k));
        end
        push_sync();
        exp_q.push_back(8'hD5); exp_q.push_back(8'hC5);
        chk_stream("t4");

        // Fill to 14 words with output stalled, then overflow a packet
        do_reset();
        drain("t3 sync");
        push_sync();
        chk_stream("t3 sync");
        data_ready = 1'b0;
        for (int k = 0; k < 14; k++) begin
            w = {4'hA, 4'(k), 4'h5, 4'(k)};
            put(w, 1'b1, 1'(k == 13), 1'b0);
        end
        step(2);
        chk("t3 fill14", 32'(fill), 32'd14);
        chk("t3 stalled_valid", 32'(data_valid), 32'd1);
        chk("t3 stalled_byte", 32'(data_out), 32'h50);
        ovf_seen = 0;
        put(16'hEE01, 1'b1, 1'b0, 1'b0);
        put(16'hEE02, 1'b1, 1'b0, 1'b0);
        put(16'hEE03, 1'b1, 1'b1, 1'b0);
        chk("t3 overflow_on", 32'(overflow), 32'd1);
        chk("t3 fill_after_drop", 32'(fill), 32'd14);
`ifdef PKT_TX_DROP_COUNT_EN
        chk("t3 drop_count", 32'(drop_count), 32'd1);
`endif
        step(40);
        chk("t3 overflow_cycles", 32'(ovf_seen), 32'd15);
        chk("t3 overflow_off", 32'(overflow), 32'd0);
        chk("t3 fill_hold", 32'(fill), 32'd14);
        chk("t3 byte_hold", 32'(data_out), 32'h50);

        // Ready pattern 1,0,0,1 inside a word, then drain across the pointer wrap
        data_ready = 1'b1;
        step();
        data_ready = 1'b0;
        chk("t5 stall0", 32'(data_out), 32'hA0);
        step();
        chk("t5 stall1", 32'(data_out), 32'hA0);
        step();
        chk("t5 stall2", 32'(data_out), 32'hA0);
        chk("t5 stall_valid", 32'(data_valid), 32'd1);
        data_ready = 1'b1;
        drain("t5");
        for (int k = 0; k < 14; k++) begin
            exp_q.push_back({4'h5, 4'(k)}); exp_q.push_back({4'hA, 4'(k)});
        end
        chk_stream("t5");
        chk("t5 fill_end", 32'(fill), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
